hazard_control_unit: RTL and testbench

- Pipeline hazard controller for the 5-stage RISC-V core.
- Consumes the stage information that the IF_ID and ID_EX registers hold, and drives their write-enable and flush ports, plus the PC write-enable.
- Handles three hazard classes:
  - load-use data hazards (one-bubble stall)
  - taken branches resolved in EX (flush, with an optional extra penalty window)
  - data-memory busy (global freeze)
- Keeps saturating stall and flush performance counters.

---
 rtl/hazard_control_unit.sv | 150 +++++++++++++++
 tb/tb_hazard_control_unit.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_control_unit.sv
// hazard_control_unit
//   Pipeline hazard controller for the 5-stage RISC-V core. Detects load-use
//   hazards between ID and EX, squashes wrong-path instructions after a taken
//   branch resolved in EX, and freezes the pipeline while data memory is busy.
//   Also keeps saturating stall/flush performance counters.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   0 RUN        | normal issue; load-use or taken branch may be detected
//   1 LOAD_STALL | bubble was inserted last cycle; consumer re-checks hazard
//   2 FLUSH      | extra branch-penalty cycles, IF_ID/ID_EX squashed
//   3 (unused)   | behaves as RUN and leaves on the next edge
//
// Ports
//   clk, rst                 core clock, synchronous active-high reset
//   id_rs1/id_rs2            source register fields of the instruction in ID
//   id_uses_rs1/id_uses_rs2  ID instruction actually reads that source
//   ex_rd, ex_mem_read       destination and load flag of the EX instruction
//   ex_branch_taken          branch in EX resolved taken this cycle
//   mem_busy                 data memory not ready, freeze everything
//   pc_write, if_id_write    load enables for PC and IF_ID
//   if_id_flush, id_ex_flush clear IF_ID / bubble ID_EX at the next edge
//   ex_mem_hold              EX_MEM and MEM_WB hold contents
//   state                    current FSM state
//   stall_count, flush_count saturating performance counters
module hazard_control_unit #(
    parameter int BRANCH_PENALTY = 1,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_branch_taken,
    input  logic             mem_busy,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_hold,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [1:0] ST_RUN        = 2'd0;
    localparam logic [1:0] ST_LOAD_STALL = 2'd1;
    localparam logic [1:0] ST_FLUSH      = 2'd2;

    localparam logic [3:0]       PEN_INIT = 4'(BRANCH_PENALTY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [1:0] state_q;
    logic [1:0] state_d;
    logic [3:0] pen_cnt;
    logic [3:0] pen_d;
    logic       stall_inc;
    logic       flush_inc;
    logic       load_use;

    // x0 is hardwired zero, so a load "writing" it can never hazard.
    assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                      ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                       (id_uses_rs2 && (id_rs2 == ex_rd)));

    assign state = state_q;

    always_comb begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        ex_mem_hold = 1'b0;
        state_d     = state_q;
        pen_d       = pen_cnt;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;

        if (rst) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (mem_busy) begin
            // Global freeze: branch/load-use are re-presented once busy clears.
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            ex_mem_hold = 1'b1;
            stall_inc   = 1'b1;
        end else begin
            case (state_q)
                ST_FLUSH: begin
                    // EX holds a bubble here, so ex_branch_taken is ignored.
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    pen_d       = pen_cnt - 4'd1;
                    if (pen_cnt <= 4'd1) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    // RUN, LOAD_STALL and the unused encoding share this path.
                    if (ex_branch_taken) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                        flush_inc   = 1'b1;
                        if (BRANCH_PENALTY > 1) begin
                            state_d = ST_FLUSH;
                            pen_d   = PEN_INIT;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end else if (load_use) begin
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        id_ex_flush = 1'b1;
                        stall_inc   = 1'b1;
                        state_d     = ST_LOAD_STALL;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            pen_cnt     <= 4'd0;
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            state_q <= state_d;
            pen_cnt <= pen_d;
            if (stall_inc && (stall_count != CNT_MAX)) begin
                stall_count <= stall_count + CNT_ONE;
            end
            if (flush_inc && (flush_count != CNT_MAX)) begin
                flush_count <= flush_count + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_hazard_control_unit.sv
module tb_hazard_control_unit;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       mr;
        logic       br;
        logic       busy;
    } stim_t;

    // {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_hold, state, stall, flush}
    typedef struct packed {
        logic [4:0] ctl;
        logic [1:0] st;
        logic [3:0] sc;
        logic [3:0] fc;
    } exp_t;

    localparam logic [4:0] NORM  = 5'b11000;
    localparam logic [4:0] STALL = 5'b00010;
    localparam logic [4:0] FLSH  = 5'b11110;
    localparam logic [4:0] BUSY  = 5'b00001;
    localparam logic [4:0] RSTO  = 5'b00110;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken, mem_busy;
    logic       pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_hold;
    logic [1:0] state;
    logic [3:0] stall_count, flush_count;
    logic [14:0] obs;

    int checks   = 0;
    int failures = 0;
    exp_t sb[$];

    hazard_control_unit #(.BRANCH_PENALTY(3), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
        .pc_write(pc_write), .if_id_write(if_id_write),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .ex_mem_hold(ex_mem_hold), .state(state),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    assign obs = {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_hold,
                  state, stall_count, flush_count};

    function automatic stim_t S(logic r, logic [4:0] rs1, logic [4:0] rs2, logic u1, logic u2,
                                logic [4:0] rd, logic mr, logic br, logic busy);
        S = '{rst: r, rs1: rs1, rs2: rs2, u1: u1, u2: u2, rd: rd, mr: mr, br: br, busy: busy};
    endfunction

    function automatic exp_t E(logic [4:0] ctl, logic [1:0] st, logic [3:0] sc, logic [3:0] fc);
        E = '{ctl: ctl, st: st, sc: sc, fc: fc};
    endfunction

    // Applies one cycle of stimulus just after a rising edge and returns at
    // a mid-cycle sample point, well away from either edge.
    task automatic drive(input stim_t s);
        @(posedge clk);
        #1;
        rst             = s.rst;
        id_rs1          = s.rs1;
        id_rs2          = s.rs2;
        id_uses_rs1     = s.u1;
        id_uses_rs2     = s.u2;
        ex_rd           = s.rd;
        ex_mem_read     = s.mr;
        ex_branch_taken = s.br;
        mem_busy        = s.busy;
        #3;
    endtask

    task automatic do_reset();
        drive(S(1, 0, 0, 0, 0, 0, 0, 0, 0));
        drive(S(1, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic test_reset();
        stim_t s[$];
        exp_t  e[$];
        exp_t  x;
        drive(S(1, 0, 0, 0, 0, 0, 0, 0, 0));
        s.push_back(S(1, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(E(RSTO, 0, 0, 0));
        s.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(E(NORM, 0, 0, 0));
        s.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(E(NORM, 0, 0, 0));
        for (int i = 0; i < s.size(); i++) begin
            drive(s[i]);
            sb.push_back(e[i]);
            x = sb.pop_front();
            checks++;
            if (obs !== x) begin
                failures++;
                $display("FAIL reset step %0d got=%h exp=%h", i, obs, x);
            end
        end
    endtask

    task automatic test_load_use();
        stim_t s[$];
        exp_t  e[$];
        exp_t  x;
        do_reset();
        s.push_back(S(0, 0, 5, 0, 1, 5, 1, 0, 0)); e.push_back(E(STALL, 0, 0, 0));
        s.push_back(S(0, 0, 5, 0, 1, 5, 0, 0, 0)); e.push_back(E(NORM,  1, 1, 0));
        s.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(E(NORM,  0, 1, 0));
        // rs1 path
        s.push_back(S(0, 9, 0, 1, 0, 9, 1, 0, 0)); e.push_back(E(STALL, 0, 1, 0));
        s.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(E(NORM,  1, 2, 0));
        for (int i = 0; i < s.size(); i++) begin
            drive(s[i]);
            sb.push_back(e[i]);
            x = sb.pop_front();
            checks++;
            if (obs !== x) begin
                failures++;
                $display("FAIL load_use step %0d got=%h exp=%h", i, obs, x);
            end
        end
    endtask

    task automatic test_x0_unused();
        stim_t s[$];
        exp_t  e[$];
        exp_t  x;
        do_reset();
        s.push_back(S(0, 0, 0, 1, 1, 0, 1, 0, 0)); e.push_back(E(NORM, 0, 0, 0));
        s.push_back(S(0, 7, 3, 0, 1, 7, 1, 0, 0)); e.push_back(E(NORM, 0, 0, 0));
        s.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(E(NORM, 0, 0, 0));
        for (int i = 0; i < s.size(); i++) begin
            drive(s[i]);
            sb.push_back(e[i]);
            x = sb.pop_front();
            checks++;
            if (obs !== x) begin
                failures++;
                $display("FAIL x0_unused step %0d got=%h exp=%h", i, obs, x);
            end
        end
    endtask

    task automatic test_back_to_back();
        stim_t s[$];
        exp_t  e[$];
        exp_t  x;
        do_reset();
        s.push_back(S(0, 0, 4, 0, 1, 4, 1, 0, 0)); e.push_back(E(STALL, 0, 0, 0));
        s.push_back(S(0, 0, 4, 0, 1, 4, 1, 0, 0)); e.push_back(E(STALL, 1, 1, 0));
        s.push_back(S(0, 0, 4, 0, 1, 4, 0, 0, 0)); e.push_back(E(NORM,  1, 2, 0));
        s.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(E(NORM,  0, 2, 0));
        for (int i = 0; i < s.size(); i++) begin
            drive(s[i]);
            sb.push_back(e[i]);
            x = sb.pop_front();
            checks++;
            if (obs !== x) begin
                failures++;
                $display("FAIL back_to_back step %0d got=%h exp=%h", i, obs, x);
            end
        end
    endtask

    task automatic test_branch();
        stim_t s[$];
        exp_t  e[$];
        exp_t  x;
        do_reset();
        s.push_back(S(0, 0, 5, 0, 1, 5, 1, 1, 0)); e.push_back(E(FLSH, 0, 0, 0));
        s.push_back(S(0, 0, 0, 0, 0, 0, 0, 1, 0)); e.push_back(E(FLSH, 2, 0, 1));
        s.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(E(FLSH, 2, 0, 1));
        s.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(E(NORM, 0, 0, 1));
        for (int i = 0; i < s.size(); i++) begin
            drive(s[i]);
            sb.push_back(e[i]);
            x = sb.pop_front();
            checks++;
            if (obs !== x) begin
                failures++;
                $display("FAIL branch step %0d got=%h exp=%h", i, obs, x);
            end
        end
    endtask

    task automatic test_busy_in_flush();
        stim_t s[$];
        exp_t  e[$];
        exp_t  x;
        do_reset();
        s.push_back(S(0, 0, 0, 0, 0, 0, 0, 1, 0)); e.push_back(E(FLSH, 0, 0, 0));
        s.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 1)); e.push_back(E(BUSY, 2, 0, 1));
        s.push_back(S(0, 0, 0, 0, 0, 0, 0, 1, 1)); e.push_back(E(BUSY, 2, 1, 1));
        s.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 1)); e.push_back(E(BUSY, 2, 2, 1));
        s.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 1)); e.push_back(E(BUSY, 2, 3, 1));
        s.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(E(FLSH, 2, 4, 1));
        s.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(E(FLSH, 2, 4, 1));
        s.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(E(NORM, 0, 4, 1));
        // busy in RUN masks a coincident branch and load-use
        s.push_back(S(0, 0, 6, 0, 1, 6, 1, 1, 1)); e.push_back(E(BUSY, 0, 4, 1));
        s.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(E(NORM, 0, 5, 1));
        for (int i = 0; i < s.size(); i++) begin
            drive(s[i]);
            sb.push_back(e[i]);
            x = sb.pop_front();
            checks++;
            if (obs !== x) begin
                failures++;
                $display("FAIL busy_flush step %0d got=%h exp=%h", i, obs, x);
            end
        end
    endtask

    task automatic test_saturation_reset();
        stim_t s[$];
        exp_t  e[$];
        exp_t  x;
        do_reset();
        for (int k = 0; k < 20; k++) begin
            s.push_back(S(0, 0, 5, 0, 1, 5, 1, 0, 0));
            e.push_back(E(STALL, (k == 0) ? 2'd0 : 2'd1, (k > 15) ? 4'd15 : 4'(k), 0));
        end
        s.push_back(S(1, 0, 5, 0, 1, 5, 1, 0, 0)); e.push_back(E(RSTO, 1, 15, 0));
        s.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(E(NORM, 0, 0, 0));
        for (int i = 0; i < s.size(); i++) begin
            drive(s[i]);
            sb.push_back(e[i]);
            x = sb.pop_front();
            checks++;
            if (obs !== x) begin
                failures++;
                $display("FAIL saturation step %0d got=%h exp=%h", i, obs, x);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        ex_mem_read = 1'b0; ex_branch_taken = 1'b0; mem_busy = 1'b0;
        test_reset();
        test_load_use();
        test_x0_unused();
        test_back_to_back();
        test_branch();
        test_busy_in_flush();
        test_saturation_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
